// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver with centre sampling.
// Optional even parity enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int BAUD_SCALE = 10416
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       pin,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CW = $clog2(BAUD_SCALE);
    // The counter reloads to N-1 so that it expires N cycles after the load.
    localparam logic [CW-1:0] HALF_LD = CW'(BAUD_SCALE / 2 - 1);
    localparam logic [CW-1:0] FULL_LD = CW'(BAUD_SCALE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    state_t         state;
    state_t         nxt;
    logic           s1;
    logic           rx_s;
    logic           rx_d;
    logic [CW-1:0]  cnt;
    logic [2:0]     bitn;
    logic [7:0]     sh;
    logic           tick;
    logic           fall;
    logic           load_half;
    logic           load_full;
    logic           shift;
    logic           done_ok;
    logic           done_err;

    assign tick = (cnt == '0);
    assign fall = rx_d & ~rx_s;
    assign busy = (state != IDLE);

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1   <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            s1   <= pin;
            rx_s <= s1;
            rx_d <= rx_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= nxt;
    end

    // Next-state logic and datapath controls.
    always_comb begin
        nxt       = state;
        load_half = 1'b0;
        load_full = 1'b0;
        shift     = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    nxt       = START;
                    load_half = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        nxt = IDLE;
                    end else begin
                        nxt       = DATA;
                        load_full = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift     = 1'b1;
                    load_full = 1'b1;
                    if (bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        nxt = PARITY;
`else
                        nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    load_full = 1'b1;
                    nxt       = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        done_ok = 1'b1;
                        nxt     = IDLE;
                    end else begin
                        done_err = 1'b1;
                        nxt      = BRK;
                    end
                end
            end
            BRK: begin
                if (rx_s) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Bit timer, bit index, shift register and registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt       <= '0;
            bitn      <= 3'd0;
            sh        <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (load_half)      cnt <= HALF_LD;
            else if (load_full) cnt <= FULL_LD;
            else if (!tick)     cnt <= cnt - 1'b1;
            if (load_half)  bitn <= 3'd0;
            else if (shift) bitn <= bitn + 3'd1;
            if (shift) sh <= {rx_s, sh[7:1]};
            if (done_ok || done_err) data <= sh;
            valid     <= done_ok;
            frame_err <= done_err;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    // Capture the parity mismatch, report it alongside a good stop bit.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (load_half) par_bad <= 1'b0;
            else if (state == PARITY && tick) par_bad <= rx_s ^ (^sh);
            parity_err <= done_ok & par_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked by a scoreboard.
// Expected bytes, flags and strobe cycles come from the frame rules.
module tb_uart_rx;

    localparam int B    = 16;
    localparam int HALF = B / 2;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       pin = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx #(.BAUD_SCALE(B)) dut (
        .clk(clk),
        .nreset(nreset),
        .pin(pin),
        .data(data),
        .valid(valid),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] d;
        logic       pe;
        int         c;
    } exp_t;

    exp_t q[$];
    int   npass = 0;
    int   ntot  = 0;

    task automatic chk(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (nreset && (valid || frame_err || parity_err)) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", {frame_err, valid}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("kind", {frame_err, valid}, e.kind);
                chk("data", data, e.d);
                chk("parity_err", parity_err, e.pe);
                chk("strobe_cycle", cyc, e.c);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic hold(input logic v);
        pin = v;
        repeat (B) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pin = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic par,
                        input logic stop);
        exp_t e;
        e.kind = stop ? 2'b01 : 2'b10;
        e.d    = b;
        e.pe   = (P == 1) && stop && (par != ^b);
        e.c    = cyc + 2 + HALF + (9 + P) * B + 1;
        q.push_back(e);
        hold(1'b0);
        for (int i = 0; i < 8; i++) hold(b[i]);
        if (P == 1) hold(par);
        hold(stop);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_parity_err"}, parity_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int k;
        int w;
        logic [7:0] rb;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        nreset = 1'b1;
        idle(5);

        send(8'hA5, ^8'hA5, 1'b1);
        idle(7);

        // Short low pulse: must be rejected as a glitch.
        pin = 1'b0;
        k = cyc + 2;
        repeat (4) @(posedge clk);
        #1;
        pin = 1'b1;
        while (cyc < k + 8) @(negedge clk);
        chk("glitch_busy_hi", busy, 1);
        @(negedge clk);
        chk("glitch_busy_lo", busy, 0);
        @(posedge clk);
        #1;
        idle(4);
        send(8'h3C, ^8'h3C, 1'b1);
        idle(5);

        // Stop bit low followed by a long break.
        send(8'h55, ^8'h55, 1'b0);
        pin = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        @(negedge clk);
        chk("break_busy", busy, 1);
        @(posedge clk);
        #1;
        idle(4);
        @(negedge clk);
        chk("break_exit", busy, 0);
        @(posedge clk);
        #1;
        send(8'h0F, ^8'h0F, 1'b1);

        // Back-to-back frames.
        send(8'h00, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b1);
        idle(6);

        // Reset in the middle of the data bits.
        hold(1'b0);
        hold(1'b1);
        hold(1'b0);
        hold(1'b0);
        nreset = 1'b0;
        pin = 1'b1;
        @(negedge clk);
        chk_reset_vals("midreset");
        @(posedge clk);
        #1;
        nreset = 1'b1;
        idle(20);
        send(8'h7E, ^8'h7E, 1'b1);
        idle(3);

        if (P == 1) begin
            send(8'h03, 1'b1, 1'b1);
            idle(3);
            send(8'h03, 1'b0, 1'b1);
            idle(3);
        end

        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) begin
                send(rb, 1'($urandom_range(0, 1)), 1'b0);
                pin = 1'b0;
                repeat ($urandom_range(0, 30)) @(posedge clk);
                #1;
                idle($urandom_range(2, 10));
            end else begin
                send(rb, 1'($urandom_range(0, 1)), 1'b1);
                idle($urandom_range(0, 12));
            end
        end

        w = 0;
        while (q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain", q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
